// File: rtl/fxp_sum_accumulator.sv
// ---------------------------------------------------------------------------
// fxp_sum_accumulator
//
// Sums N_SAMPLES unsigned Q9.4 samples into a saturating Q(ACC_INT_W).4 frame
// total. Samples arrive on a valid/ready stream. Each completed total is
// presented on a valid/ready output together with a sticky saturation flag.
// While a total is waiting to be taken, the block accepts no input.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   clear           synchronous discard of the partial frame or the held total
//   in_valid        input sample valid
//   in_ready        block can accept a sample (registered)
//   in_integer      sample integer part, 9 bits
//   in_fractional   sample fraction, 1/16 units
//   out_valid       frame total valid (registered)
//   out_ready       downstream accepts the total
//   out_integer     total integer part, ACC_INT_W bits
//   out_fractional  total fraction, 1/16 units
//   out_overflow    frame saturated; qualified by out_valid
//   sample_cnt      samples accepted in the current frame
// ---------------------------------------------------------------------------
module fxp_sum_accumulator #(
    parameter int unsigned N_SAMPLES = 8,
    parameter int unsigned ACC_INT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8:0]           in_integer,
    input  logic [3:0]           in_fractional,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_INT_W-1:0] out_integer,
    output logic [3:0]           out_fractional,
    output logic                 out_overflow,
    output logic [7:0]           sample_cnt
);

    localparam int unsigned ACC_W    = ACC_INT_W + 4;
    localparam logic [7:0]  LAST_CNT = 8'(N_SAMPLES - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [ACC_W-1:0]     acc_r;
    logic [ACC_W-1:0]     acc_s;
    logic                 sat_r;
    logic                 sat_s;
    logic [7:0]           cnt_r;
    logic [7:0]           cnt_s;
    logic                 load_out_s;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [ACC_INT_W-1:0] out_integer_r;
    logic [3:0]           out_fractional_r;
    logic                 out_overflow_r;

    logic [ACC_W-1:0]     sample_s;
    logic [ACC_W:0]       sum_s;
    logic [ACC_W-1:0]     sat_sum_s;
    logic                 accept_s;

    // Sample widening, wide sum and clamp to all-ones on carry out of the accumulator
    always_comb begin
        sample_s  = ACC_W'({in_integer, in_fractional});
        sum_s     = {1'b0, acc_r} + {1'b0, sample_s};
        if (sum_s[ACC_W]) begin
            sat_sum_s = {ACC_W{1'b1}};
        end else begin
            sat_sum_s = sum_s[ACC_W-1:0];
        end
        // clear drops any sample presented in the same cycle
        accept_s = in_valid & in_ready_r & ~clear & (state_r == ST_ACCUM);
    end

    // Next-state, accumulator and counter update
    always_comb begin
        state_s    = state_r;
        acc_s      = acc_r;
        sat_s      = sat_r;
        cnt_s      = cnt_r;
        load_out_s = 1'b0;
        if (clear) begin
            state_s = ST_ACCUM;
            acc_s   = {ACC_W{1'b0}};
            sat_s   = 1'b0;
            cnt_s   = 8'd0;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (accept_s) begin
                        acc_s = sat_sum_s;
                        sat_s = sat_r | sum_s[ACC_W];
                        cnt_s = cnt_r + 8'd1;
                        if (cnt_r == LAST_CNT) begin
                            load_out_s = 1'b1;
                            state_s    = ST_HOLD;
                        end else begin
                            state_s    = ST_ACCUM;
                        end
                    end else begin
                        state_s = ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    // Handoff only; the next frame's first sample waits for in_ready
                    if (out_valid_r && out_ready) begin
                        state_s = ST_ACCUM;
                        acc_s   = {ACC_W{1'b0}};
                        sat_s   = 1'b0;
                        cnt_s   = 8'd0;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                default: begin
                    state_s = ST_ACCUM;
                    acc_s   = {ACC_W{1'b0}};
                    sat_s   = 1'b0;
                    cnt_s   = 8'd0;
                end
            endcase
        end
    end

    // State, accumulator and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_ACCUM;
            acc_r       <= {ACC_W{1'b0}};
            sat_r       <= 1'b0;
            cnt_r       <= 8'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            sat_r       <= sat_s;
            cnt_r       <= cnt_s;
            in_ready_r  <= (state_s == ST_ACCUM);
            out_valid_r <= (state_s == ST_HOLD);
        end
    end

    // Output total register, loaded by the frame's final accept and held afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_integer_r    <= {ACC_INT_W{1'b0}};
            out_fractional_r <= 4'd0;
            out_overflow_r   <= 1'b0;
        end else if (load_out_s) begin
            out_integer_r    <= acc_s[ACC_W-1:4];
            out_fractional_r <= acc_s[3:0];
            out_overflow_r   <= sat_s;
        end else begin
            out_integer_r    <= out_integer_r;
            out_fractional_r <= out_fractional_r;
            out_overflow_r   <= out_overflow_r;
        end
    end

    assign in_ready       = in_ready_r;
    assign out_valid      = out_valid_r;
    assign out_integer    = out_integer_r;
    assign out_fractional = out_fractional_r;
    assign out_overflow   = out_overflow_r;
    assign sample_cnt     = cnt_r;

endmodule

// File: tb/tb_fxp_sum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_fxp_sum_accumulator
//
// Three instances share clock, reset and input stimulus:
//   dut_a  N_SAMPLES=4, ACC_INT_W=16
//   dut_b  N_SAMPLES=4, ACC_INT_W=10 (saturating variant)
//   dut_c  N_SAMPLES=1, ACC_INT_W=16
// A table of four-sample frames with hand-computed totals drives dut_a/dut_b,
// followed by directed sequences for backpressure, clear and reset.
// ---------------------------------------------------------------------------
module tb_fxp_sum_accumulator;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [8:0] in_integer;
    logic [3:0] in_fractional;
    logic       out_ready;

    logic        a_in_ready, a_out_valid, a_out_overflow;
    logic [15:0] a_out_integer;
    logic [3:0]  a_out_fractional;
    logic [7:0]  a_sample_cnt;

    logic        b_in_ready, b_out_valid, b_out_overflow;
    logic [9:0]  b_out_integer;
    logic [3:0]  b_out_fractional;
    logic [7:0]  b_sample_cnt;

    logic        c_in_ready, c_out_valid, c_out_overflow;
    logic [15:0] c_out_integer;
    logic [3:0]  c_out_fractional;
    logic [7:0]  c_sample_cnt;

    int n_vec;
    int n_miss;

    fxp_sum_accumulator #(.N_SAMPLES(4), .ACC_INT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_integer(in_integer), .in_fractional(in_fractional),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_integer(a_out_integer), .out_fractional(a_out_fractional),
        .out_overflow(a_out_overflow), .sample_cnt(a_sample_cnt)
    );

    fxp_sum_accumulator #(.N_SAMPLES(4), .ACC_INT_W(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_integer(in_integer), .in_fractional(in_fractional),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_integer(b_out_integer), .out_fractional(b_out_fractional),
        .out_overflow(b_out_overflow), .sample_cnt(b_sample_cnt)
    );

    fxp_sum_accumulator #(.N_SAMPLES(1), .ACC_INT_W(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(c_in_ready),
        .in_integer(in_integer), .in_fractional(in_fractional),
        .out_valid(c_out_valid), .out_ready(out_ready),
        .out_integer(c_out_integer), .out_fractional(c_out_fractional),
        .out_overflow(c_out_overflow), .sample_cnt(c_sample_cnt)
    );

    // 100 MHz-style free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0][8:0] si;
        logic [3:0][3:0] sf;
        logic [15:0]     a_int;
        logic [3:0]      a_frac;
        logic            a_ovf;
        logic [9:0]      b_int;
        logic [3:0]      b_frac;
        logic            b_ovf;
    } frame_t;

    frame_t frames [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [8:0] i, input logic [3:0] f);
        in_valid      = 1'b1;
        in_integer    = i;
        in_fractional = f;
        step();
        in_valid      = 1'b0;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("handoff_out_valid", 32'(a_out_valid), 32'd0);
        chk("handoff_in_ready", 32'(a_in_ready), 32'd1);
        chk("handoff_cnt", 32'(a_sample_cnt), 32'd0);
    endtask

    // Main stimulus
    initial begin
        n_vec = 0; n_miss = 0;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_integer = 9'd0; in_fractional = 4'd0;

        // frame table: samples and hand-computed totals for W=16 and W=10
        frames[0].si = {9'd4, 9'd4, 9'd4, 9'd4};       frames[0].sf = {4'd1, 4'd1, 4'd1, 4'd1};
        frames[0].a_int = 16'd16;   frames[0].a_frac = 4'd4;  frames[0].a_ovf = 1'b0;
        frames[0].b_int = 10'd16;   frames[0].b_frac = 4'd4;  frames[0].b_ovf = 1'b0;
        frames[1].si = {9'd0, 9'd0, 9'd2, 9'd1};       frames[1].sf = {4'd0, 4'd0, 4'd8, 4'd12};
        frames[1].a_int = 16'd4;    frames[1].a_frac = 4'd4;  frames[1].a_ovf = 1'b0;
        frames[1].b_int = 10'd4;    frames[1].b_frac = 4'd4;  frames[1].b_ovf = 1'b0;
        frames[2].si = {9'd511, 9'd511, 9'd511, 9'd511}; frames[2].sf = {4'd15, 4'd15, 4'd15, 4'd15};
        frames[2].a_int = 16'd2047; frames[2].a_frac = 4'd12; frames[2].a_ovf = 1'b0;
        frames[2].b_int = 10'd1023; frames[2].b_frac = 4'd15; frames[2].b_ovf = 1'b1;
        frames[3].si = {9'd1, 9'd1, 9'd1, 9'd1};       frames[3].sf = {4'd0, 4'd0, 4'd0, 4'd0};
        frames[3].a_int = 16'd4;    frames[3].a_frac = 4'd0;  frames[3].a_ovf = 1'b0;
        frames[3].b_int = 10'd4;    frames[3].b_frac = 4'd0;  frames[3].b_ovf = 1'b0;
        frames[4].si = {9'd10, 9'd50, 9'd200, 9'd100}; frames[4].sf = {4'd15, 4'd9, 4'd5, 4'd3};
        frames[4].a_int = 16'd362;  frames[4].a_frac = 4'd0;  frames[4].a_ovf = 1'b0;
        frames[4].b_int = 10'd362;  frames[4].b_frac = 4'd0;  frames[4].b_ovf = 1'b0;

        // Reset
        step(); step();
        chk("rst_out_valid_low", 32'(a_out_valid), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_integer", 32'(a_out_integer), 32'd0);
        chk("rst_out_fractional", 32'(a_out_fractional), 32'd0);
        chk("rst_out_overflow", 32'(a_out_overflow), 32'd0);
        chk("rst_sample_cnt", 32'(a_sample_cnt), 32'd0);

        // N_SAMPLES=1: one sample goes straight to HOLD
        send(9'd5, 4'd3);
        chk("n1_out_valid", 32'(c_out_valid), 32'd1);
        chk("n1_out_integer", 32'(c_out_integer), 32'd5);
        chk("n1_out_fractional", 32'(c_out_fractional), 32'd3);
        chk("n1_in_ready", 32'(c_in_ready), 32'd0);
        chk("n1_a_cnt", 32'(a_sample_cnt), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("n1_handoff_valid", 32'(c_out_valid), 32'd0);
        chk("n1_handoff_ready", 32'(c_in_ready), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("n1_clear_a_cnt", 32'(a_sample_cnt), 32'd0);

        // Table-driven frames
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) begin
                chk("tbl_in_ready", 32'(a_in_ready), 32'd1);
                send(frames[r].si[k], frames[r].sf[k]);
                if (k == 2) chk("tbl_early_valid", 32'(a_out_valid), 32'd0);
            end
            chk("tbl_out_valid", 32'(a_out_valid), 32'd1);
            chk("tbl_a_integer", 32'(a_out_integer), 32'(frames[r].a_int));
            chk("tbl_a_fractional", 32'(a_out_fractional), 32'(frames[r].a_frac));
            chk("tbl_a_overflow", 32'(a_out_overflow), 32'(frames[r].a_ovf));
            chk("tbl_b_integer", 32'(b_out_integer), 32'(frames[r].b_int));
            chk("tbl_b_fractional", 32'(b_out_fractional), 32'(frames[r].b_frac));
            chk("tbl_b_overflow", 32'(b_out_overflow), 32'(frames[r].b_ovf));
            chk("tbl_cnt", 32'(a_sample_cnt), 32'd4);
            handoff();
        end

        // Backpressure: HOLD with in_valid asserted
        for (int k = 0; k < 4; k++) send(9'd4, 4'd1);
        in_valid = 1'b1; in_integer = 9'd9; in_fractional = 4'd9;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_in_ready", 32'(a_in_ready), 32'd0);
            chk("bp_out_valid", 32'(a_out_valid), 32'd1);
            chk("bp_out_integer", 32'(a_out_integer), 32'd16);
            chk("bp_out_fractional", 32'(a_out_fractional), 32'd4);
            chk("bp_cnt", 32'(a_sample_cnt), 32'd4);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("bp_release_valid", 32'(a_out_valid), 32'd0);
        chk("bp_release_ready", 32'(a_in_ready), 32'd1);
        chk("bp_release_cnt", 32'(a_sample_cnt), 32'd0);

        // clear mid-frame, with a sample presented in the clear cycle
        send(9'd3, 4'd0);
        send(9'd3, 4'd0);
        chk("clr_cnt_before", 32'(a_sample_cnt), 32'd2);
        in_valid = 1'b1; in_integer = 9'd7; in_fractional = 4'd0; clear = 1'b1;
        step();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_cnt_after", 32'(a_sample_cnt), 32'd0);
        chk("clr_in_ready", 32'(a_in_ready), 32'd1);
        for (int k = 0; k < 4; k++) send(9'd1, 4'd0);
        chk("clr_out_valid", 32'(a_out_valid), 32'd1);
        chk("clr_out_integer", 32'(a_out_integer), 32'd4);
        chk("clr_out_fractional", 32'(a_out_fractional), 32'd0);
        // clear while a total is held
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_hold_valid", 32'(a_out_valid), 32'd0);
        chk("clr_hold_ready", 32'(a_in_ready), 32'd1);
        chk("clr_hold_cnt", 32'(a_sample_cnt), 32'd0);

        // Async reset mid-frame
        send(9'd2, 4'd0);
        send(9'd2, 4'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_mid_cnt", 32'(a_sample_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 4; k++) send(9'd4, 4'd1);
        chk("arst_frame_valid", 32'(a_out_valid), 32'd1);
        chk("arst_frame_integer", 32'(a_out_integer), 32'd16);
        chk("arst_frame_fractional", 32'(a_out_fractional), 32'd4);
        // Async reset in HOLD: out_valid falls before any clock edge
        rst_n = 1'b0;
        #1;
        chk("arst_hold_valid", 32'(a_out_valid), 32'd0);
        chk("arst_hold_integer", 32'(a_out_integer), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 4; k++) send(9'd2, 4'd3);
        chk("fresh_valid", 32'(a_out_valid), 32'd1);
        chk("fresh_integer", 32'(a_out_integer), 32'd8);
        chk("fresh_fractional", 32'(a_out_fractional), 32'd12);
        chk("fresh_overflow", 32'(a_out_overflow), 32'd0);
        handoff();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
